// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty ramp sequencer for the 4-bit counter-compare PWM: duty moves toward a target one LSB per N periods.
// Optional triangle "breathe" loop between 0 and target is built when PWM_DUTY_BREATHE_EN is defined.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W   = 4,
  parameter int MAX_DUTY = 8,
  parameter int RATE_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_tick,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DUTY_W-1:0] cfg_target,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, HOLD = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, target_q, target_d;
  logic [RATE_W-1:0] rate_q, rate_d, cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DUTY_W-1:0] tgt_clamp, dst, nxt_duty;
  logic              ramping, accept, step_now;

  assign ramping   = (state_q == UP) || (state_q == DOWN);
  assign tgt_clamp = (cfg_target > DUTY_W'(MAX_DUTY)) ? DUTY_W'(MAX_DUTY) : cfg_target;
  assign step_now  = (rate_q == '0) || (cnt_q == rate_q - RATE_W'(1));

`ifdef PWM_DUTY_BREATHE_EN
  // low_q: the current DOWN leg heads for 0 rather than for target_q
  logic low_q, low_d;
  assign cfg_ready = !rst && (!ramping || (target_q != '0));
  assign dst       = (state_q == DOWN && low_q) ? '0 : target_q;
`else
  assign cfg_ready = !rst && !ramping;
  assign dst       = target_q;
`endif

  assign accept   = cfg_valid && cfg_ready && !abort;
  assign nxt_duty = (rate_q == '0)     ? dst :
                    (state_q == UP)    ? duty_q + DUTY_W'(1) :
                                         duty_q - DUTY_W'(1);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef PWM_DUTY_BREATHE_EN
    low_d    = low_q;
`endif
    if (abort) begin
      // freeze duty where it is; no completion pulse
      cnt_d = '0;
      if (ramping) state_d = HOLD;
`ifdef PWM_DUTY_BREATHE_EN
      low_d = 1'b0;
`endif
    end else if (accept) begin
      target_d = tgt_clamp;
      rate_d   = cfg_rate;
      cnt_d    = '0;
`ifdef PWM_DUTY_BREATHE_EN
      low_d    = 1'b0;
`endif
      if (tgt_clamp > duty_q)      state_d = UP;
      else if (tgt_clamp < duty_q) state_d = DOWN;
      else begin
        state_d = HOLD;
        done_d  = 1'b1;
      end
    end else if (period_tick && ramping) begin
      if (step_now) begin
        cnt_d  = '0;
        duty_d = nxt_duty;
        if (nxt_duty == dst) begin
          done_d  = 1'b1;
          state_d = HOLD;
`ifdef PWM_DUTY_BREATHE_EN
          if (target_q != '0) begin
            if (state_q == DOWN && low_q) begin
              state_d = UP;
              low_d   = 1'b0;
            end else begin
              state_d = DOWN;
              low_d   = 1'b1;
            end
          end
`endif
        end
      end else begin
        cnt_d = cnt_q + RATE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      rate_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef PWM_DUTY_BREATHE_EN
      low_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef PWM_DUTY_BREATHE_EN
      low_q    <= low_d;
`endif
    end
  end

  assign duty  = duty_q;
  assign done  = done_q;
  assign busy  = ramping;
  assign state = state_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl: ramps, clamping, jumps, abort, async reset, breathe loop.
module tb_pwm_duty_ramp_ctrl;
  logic       clk = 1'b0;
  logic       rst, period_tick, cfg_valid, cfg_ready, abort, busy, done;
  logic [3:0] cfg_target, duty;
  logic [7:0] cfg_rate;
  logic [1:0] state;
  int total = 0;
  int bad   = 0;

  pwm_duty_ramp_ctrl #(.DUTY_W(4), .MAX_DUTY(8), .RATE_W(8)) dut (
    .clk(clk), .rst(rst), .period_tick(period_tick), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_target(cfg_target), .cfg_rate(cfg_rate),
    .abort(abort), .duty(duty), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) period_tick = 1'b1;
    @(negedge clk) period_tick = 1'b0;
  endtask

  task automatic cfg(input int t, input int r);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_target = 4'(t); cfg_rate = 8'(r);
    @(negedge clk) cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; period_tick = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    cfg_target = '0; cfg_rate = '0;
    idle(2);
    chk("rst_duty", duty, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    #1 chk("rst_ready", cfg_ready, 1);

`ifndef PWM_DUTY_BREATHE_EN
    // 1: 0 -> 5 at two periods per step
    cfg(5, 2);
    chk("t1_state", state, 1);
    chk("t1_busy", busy, 1);
    chk("t1_ready", cfg_ready, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("t1_duty%0d", i), duty, i / 2);
      chk($sformatf("t1_done%0d", i), done, (i == 10) ? 1 : 0);
      chk($sformatf("t1_st%0d", i), state, (i == 10) ? 3 : 1);
      idle(6);
    end
    chk("t1_done_end", done, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_ready_end", cfg_ready, 1);

    // 2: target 12 clamps to 8, one step per period
    cfg(12, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t2_duty%0d", i), duty, 5 + i);
      chk($sformatf("t2_done%0d", i), done, (i == 3) ? 1 : 0);
    end
    tick();
    chk("t2_hold_duty", duty, 8);
    chk("t2_hold_done", done, 0);

    // 3: jump down, tick coincident with accept is ignored
    @(negedge clk);
    cfg_valid = 1'b1; cfg_target = 4'd2; cfg_rate = 8'd0; period_tick = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; period_tick = 1'b0;
    chk("t3_state", state, 2);
    chk("t3_duty_acc", duty, 8);
    tick();
    chk("t3_duty", duty, 2);
    chk("t3_done", done, 1);
    chk("t3_state_hold", state, 3);
    idle(1);
    chk("t3_done_clr", done, 0);

    // 4: ramp 0 -> 8, abort at 3 (abort beats a same-cycle tick)
    cfg(0, 0);
    tick();
    chk("t4_zero", duty, 0);
    cfg(8, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t4_duty%0d", i), duty, i);
    end
    @(negedge clk);
    abort = 1'b1; period_tick = 1'b1;
    @(negedge clk);
    abort = 1'b0; period_tick = 1'b0;
    chk("t4_ab_duty", duty, 3);
    chk("t4_ab_state", state, 3);
    chk("t4_ab_done", done, 0);
    chk("t4_ab_busy", busy, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("t4_frz%0d", i), duty, 3);
    end
    @(negedge clk);
    abort = 1'b1; cfg_valid = 1'b1; cfg_target = 4'd8; cfg_rate = 8'd1;
    @(negedge clk);
    abort = 1'b0; cfg_valid = 1'b0;
    chk("t4_noacc_state", state, 3);
    tick();
    chk("t4_noacc_duty", duty, 3);

    // 5: async reset mid-ramp, then same-value config
    cfg(8, 1);
    tick();
    chk("t5_duty4", duty, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_duty", duty, 0);
    chk("t5_rst_state", state, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("t5_ready", cfg_ready, 1);
    cfg(0, 5);
    chk("t5_hold", state, 3);
    chk("t5_done", done, 1);
    idle(1);
    chk("t5_done_clr", done, 0);
`else
    // 6: breathe between 0 and 3, abort at 2
    begin
      int bseq[10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
      cfg(3, 1);
      for (int i = 0; i < 10; i++) begin
        tick();
        chk($sformatf("t6_duty%0d", i), duty, bseq[i]);
        chk($sformatf("t6_done%0d", i), done, (bseq[i] == 3 || bseq[i] == 0) ? 1 : 0);
        chk($sformatf("t6_ready%0d", i), cfg_ready, 1);
      end
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("t6_ab_state", state, 3);
      chk("t6_ab_duty", duty, 2);
      chk("t6_ab_done", done, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
